// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the RV32I core; owns the PC.
// Optional performance counters (cycle_cnt, instret_cnt) are built when SEQ_PERF_CNT_EN is defined.
module exec_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_reg_we,
    input  logic        dec_illegal,
    input  logic        dec_halt,
    output logic [31:0] pc,
    input  logic [31:0] pc_next,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        halted,
    output logic        trap
`ifdef SEQ_PERF_CNT_EN
   ,output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    // state  | meaning
    // FETCH  | imem request held on pc until imem_ack, then latch instr
    // DECODE | decoder settles on instr; illegal/halt checks
    // EXEC   | execute stage registers ALU result and pc_next
    // MEM    | data access held until dmem_ack
    // WB     | register write strobe, pc <= pc_next
    // HALTED | ECALL/EBREAK seen, terminal until reset
    // TRAP   | illegal instruction seen, terminal until reset
    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALTED, TRAP
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        imem_req_q, imem_req_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic        rf_we_q, rf_we_d;
    logic        wb_sel_q, wb_sel_d;
    logic        halted_q, halted_d;
    logic        trap_q, trap_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_illegal)   state_d = TRAP;
                else if (dec_halt) state_d = HALTED;
                else               state_d = EXEC;
            end
            EXEC: begin
                if (dec_is_load || dec_is_store) state_d = MEM;
                else                             state_d = WB;
            end
            MEM: begin
                if (dmem_ack) state_d = WB;
            end
            WB: begin
                pc_d    = pc_next;
                state_d = FETCH;
            end
            HALTED:  state_d = HALTED;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        // Outputs are registered from the next state so they never follow the acks combinationally
        imem_req_d = (state_d == FETCH);
        dmem_req_d = (state_d == MEM);
        dmem_we_d  = (state_d == MEM) && dec_is_store;
        rf_we_d    = (state_d == WB) && dec_reg_we && !dec_is_store;
        wb_sel_d   = (state_d == WB) && dec_is_load;
        halted_d   = (state_d == HALTED);
        trap_d     = (state_d == TRAP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            wb_sel_q   <= 1'b0;
            halted_q   <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            wb_sel_q   <= wb_sel_d;
            halted_q   <= halted_d;
            trap_q     <= trap_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign rf_we     = rf_we_q;
    assign wb_sel    = wb_sel_q;
    assign halted    = halted_q;
    assign trap      = trap_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != HALTED && state_q != TRAP) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (state_q == WB) instret_cnt_d = instret_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: vector table driven through a memory/decoder model, scoreboard-checked per instruction.
module tb_exec_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0, instr, pc, pc_next = 32'd0;
    logic        dec_is_load = 1'b0, dec_is_store = 1'b0, dec_reg_we = 1'b0;
    logic        dec_illegal = 1'b0, dec_halt = 1'b0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic        rf_we, wb_sel, halted, trap;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    exec_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_reg_we(dec_reg_we),
        .dec_illegal(dec_illegal), .dec_halt(dec_halt),
        .pc(pc), .pc_next(pc_next),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted), .trap(trap)
`ifdef SEQ_PERF_CNT_EN
       ,.cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp_v, $time);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        bit          ld, st, we;
        int          iw, dw;
        bit          stray;
        logic [31:0] pcn;
        int          lat, rf;
        bit          wbs;
        int          dreq, dwe;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc_after;
        int          lat, rf;
        bit          wbs;
        int          dreq, dwe;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: an instruction spans from one imem_req rise to the next
    bit          mon_en = 1'b0;
    bit          m_active = 1'b0, m_prev = 1'b0, m_got = 1'b0;
    bit          m_instr_bad, m_addr_bad, m_pc_bad, m_wbs;
    int          m_cyc, m_rf, m_dreq, m_dwe;
    logic [31:0] m_pc0, m_instr;

    task automatic finish_instr();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("latency", m_cyc, e.lat);
        chk("rf_we_cycles", m_rf, e.rf);
        chk("wb_sel", {31'd0, m_wbs}, {31'd0, e.wbs});
        chk("dmem_req_cycles", m_dreq, e.dreq);
        chk("dmem_we_cycles", m_dwe, e.dwe);
        chk("pc_after_wb", pc, e.pc_after);
        chk("instr_latched", m_instr, e.word);
        chk("instr_stable", {31'd0, m_instr_bad}, 32'd0);
        chk("imem_addr_eq_pc", {31'd0, m_addr_bad}, 32'd0);
        chk("pc_stable_until_wb", {31'd0, m_pc_bad}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            m_active = 1'b0;
            m_prev   = 1'b0;
        end else begin
            if (imem_req && !m_prev) begin
                if (m_active) finish_instr();
                m_active = 1'b1; m_cyc = 0; m_pc0 = pc; m_rf = 0; m_wbs = 1'b0;
                m_dreq = 0; m_dwe = 0; m_got = 1'b0; m_instr = 32'd0;
                m_instr_bad = 1'b0; m_addr_bad = 1'b0; m_pc_bad = 1'b0;
            end
            if (m_active) begin
                m_cyc++;
                if (rf_we) m_rf++;
                if (wb_sel) m_wbs = 1'b1;
                if (dmem_req) m_dreq++;
                if (dmem_we) m_dwe++;
                if (imem_addr !== pc) m_addr_bad = 1'b1;
                if (pc !== m_pc0) m_pc_bad = 1'b1;
                if (!imem_req && !m_got) begin
                    m_instr = instr;
                    m_got   = 1'b1;
                end else if (m_got && instr !== m_instr) begin
                    m_instr_bad = 1'b1;
                end
            end
            m_prev = imem_req;
        end
    end

    task automatic clear_dec();
        dec_is_load = 1'b0; dec_is_store = 1'b0; dec_reg_we = 1'b0;
        dec_illegal = 1'b0; dec_halt = 1'b0;
    endtask

    // Leaves the bench at the negedge of the second post-reset FETCH cycle
    task automatic do_reset(input bit en_mon);
        @(negedge clk);
        mon_en = 1'b0; rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        clear_dec();
        @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd1);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_instr", instr, NOP);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        mon_en = en_mon;
        @(negedge clk);
        chk("rel_imem_req", {31'd0, imem_req}, 32'd1);
    endtask

    // Entered and left at the negedge of a FETCH cycle
    task automatic run_vec(input vec_t v);
        bit ok;
        exp_q.push_back('{v.word, v.pcn, v.lat, v.rf, v.wbs, v.dreq, v.dwe});
        imem_rdata = v.word;
        for (int i = 0; i < v.iw; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
        end
        imem_ack = 1'b1;
        dec_is_load = v.ld; dec_is_store = v.st; dec_reg_we = v.we;
        dec_illegal = 1'b0; dec_halt = 1'b0; pc_next = v.pcn;
        @(negedge clk);
        imem_ack = 1'b0;
        if (v.ld || v.st) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (dmem_req) begin ok = 1'b1; break; end
                dmem_ack = v.stray;
                @(negedge clk);
            end
            if (!ok) chk("dmem_req_timeout", 32'd1, 32'd0);
            for (int i = 0; i < v.dw; i++) begin
                dmem_ack = 1'b0;
                @(negedge clk);
            end
            dmem_ack = 1'b1;
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) begin ok = 1'b1; break; end
            imem_ack = v.stray;
            @(negedge clk);
        end
        if (!ok) chk("imem_req_timeout", 32'd1, 32'd0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    // Fetch an ECALL/illegal word and watch the terminal state for 20 cycles
    task automatic stop_test(input bit ill, input bit hlt, input string nm);
        int bad;
        imem_rdata = 32'h0000_0073;
        dec_illegal = ill; dec_halt = hlt;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'b1; dmem_ack = 1'b1;
            if (imem_req || dmem_req || rf_we || pc !== RST_PC ||
                trap !== ill || halted !== (!ill && hlt)) bad++;
            @(negedge clk);
        end
        chk({nm, "_trap"}, {31'd0, trap}, {31'd0, ill});
        chk({nm, "_halted"}, {31'd0, halted}, {31'd0, !ill && hlt});
        chk({nm, "_frozen_cycles_bad"}, bad, 32'd0);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        clear_dec();
    endtask

    vec_t vecs[7];

    initial begin
        //          word          ld    st    we    iw dw stray pc_next        lat rf wbs  dreq dwe
        vecs[0] = '{32'h00500093, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0000_1004, 4, 1, 1'b0, 0, 0};
        vecs[1] = '{32'h0000a103, 1'b1, 1'b0, 1'b1, 0, 3, 1'b0, 32'h0000_1008, 8, 1, 1'b1, 4, 0};
        vecs[2] = '{32'h0020a223, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 32'h0000_100C, 5, 0, 1'b0, 1, 1};
        vecs[3] = '{32'h00108093, 1'b0, 1'b0, 1'b1, 2, 0, 1'b1, 32'h0000_1010, 6, 1, 1'b0, 0, 0};
        vecs[4] = '{32'h12345678, 1'b1, 1'b1, 1'b1, 1, 1, 1'b1, 32'h0000_0100, 7, 0, 1'b1, 2, 2};
        vecs[5] = '{32'h00208463, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'hFFFF_FFFC, 4, 0, 1'b0, 0, 0};
        vecs[6] = '{32'h00310113, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0000_0003, 4, 1, 1'b0, 0, 0};

        do_reset(1'b1);
        foreach (vecs[i]) run_vec(vecs[i]);
        @(negedge clk);
        mon_en = 1'b0;
        chk("sb_leftover", exp_q.size(), 32'd0);

        // Reset asserted mid-MEM with dmem_ack pending
        imem_rdata = 32'h0000a183;
        imem_ack = 1'b1; dec_is_load = 1'b1; dec_reg_we = 1'b1; pc_next = 32'h0000_0007;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_mem_dmem_req", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0; dmem_ack = 1'b1;
        @(negedge clk);
        chk("mid_mem_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_mem_rst_pc", pc, RST_PC);
        chk("mid_mem_rst_instr", instr, NOP);
        chk("mid_mem_rst_imem_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b1; dmem_ack = 1'b0;
        clear_dec();
        @(negedge clk);
        chk("mid_mem_rel_imem_req", {31'd0, imem_req}, 32'd1);
        chk("mid_mem_rel_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_mem_rel_rf_we", {31'd0, rf_we}, 32'd0);

        do_reset(1'b0);
        stop_test(1'b1, 1'b1, "illegal_and_halt");
        do_reset(1'b0);
        stop_test(1'b0, 1'b1, "halt");
        do_reset(1'b0);

`ifdef SEQ_PERF_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("perf_rst_cycle", cycle_cnt, 32'd0);
        chk("perf_rst_instret", instret_cnt, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imem_rdata = 32'h00100093; dec_reg_we = 1'b1;
            pc_next = RST_PC + 32'(4 * (k + 1));
            imem_ack = 1'b1;
            @(negedge clk);
            imem_ack = 1'b0;
            repeat (3) @(negedge clk);
        end
        chk("perf_cycle_after_3", cycle_cnt, 32'd12);
        chk("perf_instret_after_3", instret_cnt, 32'd3);
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        @(negedge clk);
        chk("perf_cycle_wrap", cycle_cnt, 32'd0);
        clear_dec();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
